logicgates_bist: RTL and testbench
==================================

# logicgates_bist

Self-checking hardware stimulus/response engine for the 2-bit-select gate unit (sel 00 NOT, 01 AND, 10 OR, 11 XOR). It drives `sel`/`A`/`B` into the gate unit and reads back `Y`. It runs all 16 {sel,A,B} vectors, compares each response against an internal golden model, and reports an error count and pass flag. It sits beside the gate unit in silicon as the on-chip counterpart of the simulation bench.

## Interface
- `SETTLE_CYC`, default 1: cycles each vector is held before `Y` is sampled. Legal range is 1..15.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: begins a run when sampled high in IDLE or DONE.
- `sel_o` output 2: gate select driven to the gate unit.
- `a_o` output 1: operand A driven to the gate unit.
- `b_o` output 1: operand B driven to the gate unit.
- `y_i` input 1: gate unit result.
- `busy` output 1: high while a run is in progress.
- `done` output 1: high from run completion until the next `start` or `rst`.
- `pass` output 1: `done && err_count == 0`.
- `err_count` output 5: mismatches in the current or last run, range 0..16.
- `fail_map` output 16: bit k set if vector k mismatched. Populated only with the macro (see Configuration).

## Operation
- Vector index `idx[3:0]` = {sel,A,B}. Vectors are applied in order 0..15.
- Drive mapping: `sel_o`=idx[3:2], `a_o`=idx[1], `b_o`=idx[0].
- Golden model:
  - sel 00 → ~A (B is ignored)
  - sel 01 → A&B
  - sel 10 → A|B
  - sel 11 → A^B
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE, `start`=1: clear `err_count`, `fail_map` and `done`; set `idx`=0; drive vector 0; load settle counter with SETTLE_CYC-1; go to SETTLE.
- SETTLE: if counter≠0, decrement it and stay. Otherwise go to CHECK.
- CHECK: sample `y_i` and compare with the golden value.
  - On mismatch: increment `err_count` (saturating at 16) and set `fail_map[idx]`.
  - If `idx`=15, go to DONE.
  - Otherwise increment `idx`, drive the next vector, reload the counter and go to SETTLE.
- DONE: `done`=1; outputs hold the last vector.
- `busy` = (state is SETTLE or CHECK).
- All outputs are registered. `pass` is a registered copy of the DONE-entry condition.

## Timing
- Reset values: state IDLE; `sel_o`=00, `a_o`=0, `b_o`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_map`=0.
- Each vector occupies SETTLE_CYC cycles in SETTLE plus 1 cycle in CHECK.
- Vector k is stable on the outputs for ≥SETTLE_CYC full cycles before `y_i` is sampled.
- `busy` rises on the edge that samples `start`.
- `done`/`pass` rise exactly 16·(SETTLE_CYC+1) edges after the edge that samples `start`. With SETTLE_CYC=1 this is 32 edges.
- `start` while `busy`=1 is ignored. No restart and no counter change occur.
- `start` held high continuously in DONE relaunches the run on the next edge. Results from the finished run are valid for the one DONE cycle.
- `rst` mid-run: on the next edge all state returns to reset values and the partial results are discarded.
- `rst` and `start` asserted together: `rst` wins.
- `y_i` is treated as combinational from the driven outputs and is sampled only in CHECK.

## Configuration
- Macro `LOGICGATES_BIST_FAILMAP_EN`.
- Defined: `fail_map` register is implemented and updated as described in Operation.
- Undefined: no `fail_map` storage is built and `fail_map` is tied to 16'h0000. `err_count`, `pass` and timing are unchanged.

## Test plan
- Correct gate model connected, SETTLE_CYC=1, pulse `start`:
  - `busy` high for 32 cycles, then `done`=1, `pass`=1, `err_count`=0, `fail_map`=16'h0000.
  - Outputs step through sel 00→11 with A,B counting 00→11.
- `y_i` stuck at 0:
  - `err_count`=8, `pass`=0.
  - With macro: `fail_map`=16'h6E83. Without macro: `fail_map`=0.
- `y_i` = inverted golden value: `err_count`=16 (saturated), `fail_map`=16'hFFFF, `pass`=0.
- SETTLE_CYC=3 with a correct model: `done` rises 64 edges after start. A `start` pulse at cycle 10 of the run is ignored, and the run still finishes at edge 64.
- `rst` asserted at cycle 15 of a run:
  - Next edge: all outputs are at reset values.
  - A fresh `start` then completes normally with `err_count`=0.
- Back-to-back runs: after run 1 with `y_i` stuck at 1 (`err_count`=8, `fail_map`=16'h917C), run 2 with a correct model clears the results and ends with `err_count`=0 and `pass`=1.

Source files
------------

// File: rtl/logicgates_bist.sv
// On-chip stimulus/response engine for the 2-bit-select gate unit.
// Optional per-vector failure map enabled by defining LOGICGATES_BIST_FAILMAP_EN.
module logicgates_bist #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [1:0]  sel_o,
  output logic        a_o,
  output logic        b_o,
  input  logic        y_i,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [15:0] fail_map
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 5;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = ERR_W'(16);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(15);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             golden_c;
  logic             mismatch_c;
  logic             launch_c;

  // Reference gate behaviour for the vector currently driven.
  always_comb begin
    golden_c = 1'b0;
    unique case (idx_q[3:2])
      2'b00: golden_c = ~idx_q[1];
      2'b01: golden_c = idx_q[1] & idx_q[0];
      2'b10: golden_c = idx_q[1] | idx_q[0];
      2'b11: golden_c = idx_q[1] ^ idx_q[0];
      default: golden_c = 1'b0;
    endcase
  end

  assign mismatch_c = (y_i != golden_c);
  assign launch_c   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_SETTLE;
      S_SETTLE:       if (cnt_q == '0) state_d = S_CHECK;
      S_CHECK:        state_d = (idx_q == IDX_LAST) ? S_DONE : S_SETTLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; pass is latched from the DONE-entry condition.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    done_d = done_q;
    pass_d = pass_q;
    busy_d = (state_d == S_SETTLE) || (state_d == S_CHECK);
    if (launch_c) begin
      idx_d  = '0;
      cnt_d  = SETTLE_LOAD;
      err_d  = '0;
      done_d = 1'b0;
      pass_d = 1'b0;
    end else if (state_q == S_SETTLE) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end else if (state_q == S_CHECK) begin
      if (mismatch_c && (err_q != ERR_MAX)) err_d = err_q + ERR_W'(1);
      if (idx_q == IDX_LAST) begin
        done_d = 1'b1;
        pass_d = (err_d == '0);
      end else begin
        idx_d = idx_q + IDX_W'(1);
        cnt_d = SETTLE_LOAD;
      end
    end
  end

`ifdef LOGICGATES_BIST_FAILMAP_EN
  logic [15:0] map_q, map_d;

  always_comb begin
    map_d = map_q;
    if (launch_c) begin
      map_d = '0;
    end else if ((state_q == S_CHECK) && mismatch_c) begin
      map_d[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) map_q <= '0;
    else     map_q <= map_d;
  end

  assign fail_map = map_q;
`else
  assign fail_map = 16'h0000;
`endif

  assign sel_o     = idx_q[3:2];
  assign a_o       = idx_q[1];
  assign b_o       = idx_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_logicgates_bist.sv
// Bench for logicgates_bist: two instances (SETTLE_CYC 1 and 3) against a
// timeline model of the run, plus directed literal checks.
module tb_logicgates_bist;

  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst;
  logic start;
  int   mode;  // 0 correct gate, 1 stuck-0, 2 stuck-1, 3 inverted

  logic [1:0]  sel  [NI];
  logic        a    [NI];
  logic        b    [NI];
  logic        y    [NI];
  logic        busy [NI];
  logic        done [NI];
  logic        pass [NI];
  logic [4:0]  errc [NI];
  logic [15:0] fmap [NI];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  logicgates_bist #(.SETTLE_CYC(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .sel_o(sel[0]), .a_o(a[0]), .b_o(b[0]),
    .y_i(y[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(errc[0]), .fail_map(fmap[0]));

  logicgates_bist #(.SETTLE_CYC(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .sel_o(sel[1]), .a_o(a[1]), .b_o(b[1]),
    .y_i(y[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(errc[1]), .fail_map(fmap[1]));

  function automatic int s_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Truth table of the gate unit, indexed by {sel,A,B}.
  function automatic logic gold(input int k);
    int s  = (k >> 2) & 3;
    bit av = ((k >> 1) & 1) != 0;
    bit bv = (k & 1) != 0;
    case (s)
      0:       return !av;
      1:       return av && bv;
      2:       return av || bv;
      default: return av != bv;
    endcase
  endfunction

  function automatic logic resp(input int m, input int k);
    case (m)
      0:       return gold(k);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return !gold(k);
    endcase
  endfunction

  function automatic int exp_errs(input int m, input int nvec);
    int e = 0;
    for (int k = 0; k < nvec; k++) if (resp(m, k) != gold(k)) e++;
    return e;
  endfunction

  function automatic logic [15:0] exp_map(input int m, input int nvec);
    logic [15:0] r = '0;
`ifdef LOGICGATES_BIST_FAILMAP_EN
    for (int k = 0; k < nvec; k++) if (resp(m, k) != gold(k)) r[k] = 1'b1;
`endif
    return r;
  endfunction

  // Gate unit model: combinational from the driven vector.
  always_comb begin
    for (int i = 0; i < NI; i++) y[i] = resp(mode, {28'd0, sel[i], a[i], b[i]});
  end

  // Run timeline model: 0 idle, 1 running (m_n edges since start), 2 done.
  int m_state [NI];
  int m_n     [NI];
  int m_mode  [NI];
  bit armed = 1'b0;

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_state[i] = 0; m_n[i] = 0; m_mode[i] = 0;
    end
  end

  always @(posedge clk) begin
    if (rst) armed <= 1'b1;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_state[i] <= 0;
      end else if (start && m_state[i] != 1) begin
        m_state[i] <= 1;
        m_n[i]     <= 0;
        m_mode[i]  <= mode;
      end else if (m_state[i] == 1) begin
        m_n[i]     <= m_n[i] + 1;
        m_state[i] <= (m_n[i] + 1 == 16 * (s_of(i) + 1)) ? 2 : 1;
      end
    end
  end

  // Per-cycle compare of every output against the timeline model.
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < NI; i++) begin
        logic [27:0] act, exp;
        int idx, e;
        logic [15:0] fm;
        logic bz, dn, ps;
        idx = 0; e = 0; fm = '0; bz = 0; dn = 0; ps = 0;
        if (m_state[i] == 1) begin
          idx = m_n[i] / (s_of(i) + 1);
          e   = exp_errs(m_mode[i], idx);
          fm  = exp_map(m_mode[i], idx);
          bz  = 1'b1;
        end else if (m_state[i] == 2) begin
          idx = 15;
          e   = exp_errs(m_mode[i], 16);
          fm  = exp_map(m_mode[i], 16);
          dn  = 1'b1;
          ps  = (e == 0);
        end
        exp = {4'(idx), bz, dn, ps, 5'(e), fm};
        act = {sel[i], a[i], b[i], busy[i], done[i], pass[i], errc[i], fmap[i]};
        n_tests++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL cycle_model inst%0d t=%0t: got %07h expected %07h", i, $time, act, exp);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Pulse start, optionally re-pulse mid-run, wait for both instances to finish.
  task automatic run(input int mid_at, output int d0, output int d1, output int b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = -1; d1 = -1; b0 = 0;
    for (int c = 0; c < 300; c++) begin
      start = 1'b0;
      if (busy[0]) b0++;
      if (done[0] && d0 < 0) d0 = c;
      if (done[1] && d1 < 0) d1 = c;
      if (d0 >= 0 && d1 >= 0) break;
      if (c == mid_at) start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    if (d0 < 0 || d1 < 0) chk("run_timeout", 0, 1);
  endtask

  int d0, d1, b0;
  logic [15:0] m_stuck0, m_stuck1;

  initial begin
`ifdef LOGICGATES_BIST_FAILMAP_EN
    m_stuck0 = 16'h6E83; m_stuck1 = 16'h917C;
`else
    m_stuck0 = 16'h0000; m_stuck1 = 16'h0000;
`endif
    rst = 1'b1; start = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_done", int'(done[1]), 0);
    chk("reset_errc", int'(errc[0]), 0);

    // Pin the model itself.
    chk("model_stuck0_errs", exp_errs(1, 16), 8);
    chk("model_invert_errs", exp_errs(3, 16), 16);

    // Correct gate, stray start at cycle 10 must be ignored.
    mode = 0;
    run(10, d0, d1, b0);
    chk("s1_busy_cycles", b0, 32);
    chk("s1_done_edge", d0, 32);
    chk("s3_done_edge", d1, 64);
    chk("good_pass0", int'(pass[0]), 1);
    chk("good_pass1", int'(pass[1]), 1);
    chk("good_errc", int'(errc[1]), 0);
    chk("good_fmap", int'(fmap[0]), 0);

    mode = 1;
    run(-1, d0, d1, b0);
    chk("stuck0_errc", int'(errc[0]), 8);
    chk("stuck0_pass", int'(pass[0]), 0);
    chk("stuck0_fmap", int'(fmap[1]), int'(m_stuck0));

    mode = 3;
    run(-1, d0, d1, b0);
    chk("invert_errc", int'(errc[0]), 16);
`ifdef LOGICGATES_BIST_FAILMAP_EN
    chk("invert_fmap", int'(fmap[0]), 16'hFFFF);
`else
    chk("invert_fmap", int'(fmap[0]), 0);
`endif
    chk("invert_pass", int'(pass[1]), 0);

    // Reset mid-run with a faulty gate, then a clean run.
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(busy[1]), 0);
    chk("midrst_sel", int'(sel[1]), 0);
    chk("midrst_errc", int'(errc[0]), 0);
    mode = 0;
    run(-1, d0, d1, b0);
    chk("post_rst_errc", int'(errc[1]), 0);
    chk("post_rst_pass", int'(pass[1]), 1);

    // Back-to-back: stuck-1 then relaunch from DONE with a correct gate.
    mode = 2;
    run(-1, d0, d1, b0);
    chk("stuck1_errc", int'(errc[1]), 8);
    chk("stuck1_fmap", int'(fmap[0]), int'(m_stuck1));
    mode = 0;
    run(-1, d0, d1, b0);
    chk("b2b_errc", int'(errc[0]), 0);
    chk("b2b_pass", int'(pass[0]), 1);
    chk("b2b_done_edge", d1, 64);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
